branch_predictor_btb: RTL and testbench

- Parametrised dynamic branch predictor: branch target buffer plus per-entry saturating counter.
- Sits beside the program counter in IF. Combinational lookup on the fetch PC supplies the next PC.
- Resolved branches from the execute/branch stage update the table through an update port.
- Raises a registered mispredict/redirect so the pipeline can flush IF/ID and ID/EX, replacing the fixed resolve-in-MEM/predict-not-taken scheme.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_table.sv | 42 ++++
 rtl/branch_predictor_btb.sv | 122 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the BTB branch predictor: index-width helper,
// counter reset/allocate constants and the default table entry layout.
package bp_pkg;

    localparam int BP_XLEN     = 64;
    localparam int BP_TAG_BITS = 8;
    localparam int BP_CTR_BITS = 2;

    // ceil(log2(entries)); entries is a power of two so this is exact.
    function automatic int idx_w(input int entries);
        int w;
        w = 0;
        for (int i = 1; i < entries; i = i * 2) w++;
        return w;
    endfunction

    function automatic int ctr_weak_nt(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    function automatic int ctr_weak_t(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_XLEN-1:0]     target;
        logic [BP_CTR_BITS-1:0] ctr;
    } bp_entry_t;

endpackage

// File: rtl/bp_table.sv
// Register-array storage for the predictor: combinational reads for fetch
// lookup and for the update read-modify-write, one synchronous write port.
module bp_table
    import bp_pkg::*;
#(
    parameter int     ENTRIES   = 16,
    parameter int     IDXW      = idx_w(ENTRIES),
    parameter type    entry_t   = bp_entry_t,
    parameter entry_t RST_ENTRY = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] rd_idx,
    output entry_t          rd_entry,
    input  logic [IDXW-1:0] upd_idx,
    output entry_t          upd_entry,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  entry_t          wr_entry
);

    entry_t mem [ENTRIES];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation ordering matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only valid and ctr are reset; tags and targets are dead
            // while valid=0, so leaving them unreset keeps the array plain flops.
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= RST_ENTRY.valid;
                mem[i].ctr   <= RST_ENTRY.ctr;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry  = mem[rd_idx];
    assign upd_entry = mem[upd_idx];

endmodule

// File: rtl/branch_predictor_btb.sv
// BTB + saturating-counter branch predictor: zero-latency fetch lookup,
// resolved-branch training, registered mispredict/redirect and statistics.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ENTRIES   = 16,
    parameter int TAG_BITS  = 8,
    parameter int CTR_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      pred_pc_i,
    output logic                 pred_hit_o,
    output logic                 pred_taken_o,
    output logic [XLEN-1:0]      pred_next_pc_o,
    input  logic                 upd_valid_i,
    input  logic [XLEN-1:0]      upd_pc_i,
    input  logic                 upd_taken_i,
    input  logic [XLEN-1:0]      upd_target_i,
    input  logic                 upd_pred_taken_i,
    input  logic [XLEN-1:0]      upd_pred_target_i,
    output logic                 mispredict_o,
    output logic [XLEN-1:0]      redirect_pc_o,
    output logic [STAT_BITS-1:0] stat_branches_o,
    output logic [STAT_BITS-1:0] stat_mispred_o
);

    localparam int IDXW    = idx_w(ENTRIES);
    localparam int TAG_LSB = 2 + IDXW;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_t(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

    logic [IDXW-1:0]     pred_idx, upd_idx;
    logic [TAG_BITS-1:0] pred_tag, upd_tag;
    entry_t              pred_entry, upd_entry, wr_entry;
    logic                wr_en, upd_hit, mispredict_d;

    assign pred_idx = pred_pc_i[TAG_LSB-1:2];
    assign pred_tag = pred_pc_i[TAG_LSB+TAG_BITS-1:TAG_LSB];
    assign upd_idx  = upd_pc_i[TAG_LSB-1:2];
    assign upd_tag  = upd_pc_i[TAG_LSB+TAG_BITS-1:TAG_LSB];

    bp_table #(
        .ENTRIES  (ENTRIES),
        .IDXW     (IDXW),
        .entry_t  (entry_t),
        .RST_ENTRY(RST_ENTRY)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pred_idx),
        .rd_entry (pred_entry),
        .upd_idx  (upd_idx),
        .upd_entry(upd_entry),
        .wr_en    (wr_en),
        .wr_idx   (upd_idx),
        .wr_entry (wr_entry)
    );

    // Lookup sees the array before this cycle's write lands.
    assign pred_hit_o     = pred_entry.valid && (pred_entry.tag == pred_tag);
    assign pred_taken_o   = pred_hit_o && pred_entry.ctr[CTR_BITS-1];
    assign pred_next_pc_o = pred_taken_o ? pred_entry.target : pred_pc_i + XLEN'(4);

    assign upd_hit = upd_entry.valid && (upd_entry.tag == upd_tag);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        wr_en    = 1'b0;
        wr_entry = upd_entry;
        if (upd_valid_i) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken_i) begin
                    wr_entry.target = upd_target_i;
                    if (upd_entry.ctr != CTR_MAX) wr_entry.ctr = upd_entry.ctr + CTR_BITS'(1);
                end else if (upd_entry.ctr != '0) begin
                    wr_entry.ctr = upd_entry.ctr - CTR_BITS'(1);
                end
            end else if (upd_taken_i) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = upd_tag;
                wr_entry.target = upd_target_i;
                wr_entry.ctr    = CTR_WT;
            end
        end
    end

    assign mispredict_d = upd_valid_i &&
        ((upd_taken_i != upd_pred_taken_i) ||
         (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_o    <= 1'b0;
            redirect_pc_o   <= '0;
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else begin
            mispredict_o <= mispredict_d;
            if (mispredict_d) begin
                redirect_pc_o  <= upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
                stat_mispred_o <= stat_mispred_o + STAT_BITS'(1);
            end
            if (upd_valid_i) stat_branches_o <= stat_branches_o + STAT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: one task per scenario, expected
// values worked out by hand for the default parameters.
module tb_branch_predictor_btb;

    localparam int XLEN      = 64;
    localparam int STAT_BITS = 32;

    logic                 clk;
    logic                 reset;
    logic [XLEN-1:0]      pred_pc_i;
    logic                 pred_hit_o;
    logic                 pred_taken_o;
    logic [XLEN-1:0]      pred_next_pc_o;
    logic                 upd_valid_i;
    logic [XLEN-1:0]      upd_pc_i;
    logic                 upd_taken_i;
    logic [XLEN-1:0]      upd_target_i;
    logic                 upd_pred_taken_i;
    logic [XLEN-1:0]      upd_pred_target_i;
    logic                 mispredict_o;
    logic [XLEN-1:0]      redirect_pc_o;
    logic [STAT_BITS-1:0] stat_branches_o;
    logic [STAT_BITS-1:0] stat_mispred_o;

    int n_cmp = 0;
    int n_mis = 0;

    branch_predictor_btb #(
        .XLEN(XLEN), .ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2), .STAT_BITS(STAT_BITS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pred_pc_i        (pred_pc_i),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_next_pc_o   (pred_next_pc_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .upd_pred_target_i(upd_pred_target_i),
        .mispredict_o     (mispredict_o),
        .redirect_pc_o    (redirect_pc_o),
        .stat_branches_o  (stat_branches_o),
        .stat_mispred_o   (stat_mispred_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus helpers only; all comparisons live in the scenario tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [XLEN-1:0] pc, input logic taken, input logic [XLEN-1:0] tgt,
                       input logic pt, input logic [XLEN-1:0] ptg);
        upd_valid_i       = 1'b1;
        upd_pc_i          = pc;
        upd_taken_i       = taken;
        upd_target_i      = tgt;
        upd_pred_taken_i  = pt;
        upd_pred_target_i = ptg;
    endtask

    task automatic idle();
        upd_valid_i = 1'b0;
    endtask

    task automatic look(input logic [XLEN-1:0] pc);
        pred_pc_i = pc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); upd_pc_i = '0; upd_taken_i = 0; upd_target_i = '0;
        upd_pred_taken_i = 0; upd_pred_target_i = '0; pred_pc_i = '0;
        tick(); tick();
        reset = 1'b0;
        look(64'h40);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 64'h44}) begin
            n_mis++; $display("FAIL reset_lookup: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b0, 1'b0, 64'h44}); end
        n_cmp++; if ({stat_branches_o, stat_mispred_o} !== 64'h0) begin
            n_mis++; $display("FAIL reset_stats: got %h want 0", {stat_branches_o, stat_mispred_o}); end
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== 65'h0) begin
            n_mis++; $display("FAIL reset_redirect: got %h want 0", {mispredict_o, redirect_pc_o}); end
    endtask

    task automatic test_allocate();
        upd(64'h40, 1, 64'h100, 0, 64'h0); tick(); idle();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b1, 64'h100}) begin
            n_mis++; $display("FAIL alloc_mispredict: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b1, 64'h100}); end
        n_cmp++; if ({stat_branches_o, stat_mispred_o} !== {32'd1, 32'd1}) begin
            n_mis++; $display("FAIL alloc_stats: got %h want %h", {stat_branches_o, stat_mispred_o}, {32'd1, 32'd1}); end
        look(64'h40);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 64'h100}) begin
            n_mis++; $display("FAIL alloc_lookup: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b1, 64'h100}); end
        tick();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b0, 64'h100}) begin
            n_mis++; $display("FAIL pulse_one_cycle: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b0, 64'h100}); end
    endtask

    task automatic test_saturation();
        upd(64'h40, 1, 64'h100, 1, 64'h100); tick(); idle();
        n_cmp++; if ({mispredict_o, stat_branches_o} !== {1'b0, 32'd2}) begin
            n_mis++; $display("FAIL correct_taken: got %h want %h", {mispredict_o, stat_branches_o}, {1'b0, 32'd2}); end
        upd(64'h40, 1, 64'h100, 1, 64'h100); tick();
        upd(64'h40, 1, 64'h100, 1, 64'h100); tick();
        upd(64'h40, 0, 64'h0, 1, 64'h100); tick(); idle();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b1, 64'h44}) begin
            n_mis++; $display("FAIL nt_redirect: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b1, 64'h44}); end
        look(64'h40);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 64'h100}) begin
            n_mis++; $display("FAIL sat_high: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b1, 64'h100}); end
        upd(64'h40, 0, 64'h0, 1, 64'h100); tick(); idle();
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 64'h44}) begin
            n_mis++; $display("FAIL ctr_one: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b0, 64'h44}); end
        upd(64'h40, 0, 64'h0, 0, 64'h0); tick(); idle();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b0, 64'h44}) begin
            n_mis++; $display("FAIL correct_nt: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b0, 64'h44}); end
        upd(64'h40, 0, 64'h0, 0, 64'h0); tick(); idle();
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 64'h44}) begin
            n_mis++; $display("FAIL sat_low: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b0, 64'h44}); end
        upd(64'h40, 1, 64'h100, 0, 64'h0); tick(); idle();
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 64'h44}) begin
            n_mis++; $display("FAIL no_underflow: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b0, 64'h44}); end
        upd(64'h40, 1, 64'h100, 0, 64'h0); tick(); idle();
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 64'h100}) begin
            n_mis++; $display("FAIL ctr_two: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b1, 64'h100}); end
        n_cmp++; if ({stat_branches_o, stat_mispred_o} !== {32'd10, 32'd5}) begin
            n_mis++; $display("FAIL sat_stats: got %h want %h", {stat_branches_o, stat_mispred_o}, {32'd10, 32'd5}); end
        upd(64'h40, 1, 64'h180, 1, 64'h100); tick(); idle();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b1, 64'h180}) begin
            n_mis++; $display("FAIL target_mispredict: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b1, 64'h180}); end
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 64'h180}) begin
            n_mis++; $display("FAIL target_update: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b1, 64'h180}); end
    endtask

    task automatic test_alias();
        look(64'h440);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 64'h444}) begin
            n_mis++; $display("FAIL alias_miss: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b0, 1'b0, 64'h444}); end
        upd(64'h440, 1, 64'h200, 0, 64'h0); tick(); idle();
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 64'h200}) begin
            n_mis++; $display("FAIL alias_alloc: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b1, 64'h200}); end
        look(64'h40);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 64'h44}) begin
            n_mis++; $display("FAIL alias_evict: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b0, 1'b0, 64'h44}); end
        upd(64'h80, 0, 64'h0, 0, 64'h0); tick(); idle();
        look(64'h80);
        n_cmp++; if ({pred_hit_o, mispredict_o, stat_branches_o, stat_mispred_o} !== {1'b0, 1'b0, 32'd13, 32'd7}) begin
            n_mis++; $display("FAIL miss_not_taken: got %h want %h", {pred_hit_o, mispredict_o, stat_branches_o, stat_mispred_o}, {1'b0, 1'b0, 32'd13, 32'd7}); end
    endtask

    task automatic test_same_cycle();
        upd(64'h40, 1, 64'h300, 0, 64'h0);
        look(64'h40);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 64'h44}) begin
            n_mis++; $display("FAIL same_cycle_old: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b0, 1'b0, 64'h44}); end
        tick(); idle();
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 64'h300}) begin
            n_mis++; $display("FAIL same_cycle_new: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b1, 64'h300}); end
    endtask

    task automatic test_correct_pred();
        upd(64'h40, 1, 64'h300, 1, 64'h300); tick(); idle();
        n_cmp++; if ({mispredict_o, stat_branches_o, stat_mispred_o} !== {1'b0, 32'd15, 32'd8}) begin
            n_mis++; $display("FAIL correct_pred: got %h want %h", {mispredict_o, stat_branches_o, stat_mispred_o}, {1'b0, 32'd15, 32'd8}); end
    endtask

    task automatic test_back_to_back();
        upd(64'h44, 1, 64'h500, 0, 64'h0); tick();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b1, 64'h500}) begin
            n_mis++; $display("FAIL b2b_first: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b1, 64'h500}); end
        upd(64'h44, 0, 64'h0, 1, 64'h500); tick();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b1, 64'h48}) begin
            n_mis++; $display("FAIL b2b_second: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b1, 64'h48}); end
        upd(64'h48, 1, 64'h600, 1, 64'h600); tick(); idle();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b0, 64'h48}) begin
            n_mis++; $display("FAIL b2b_third: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b0, 64'h48}); end
        look(64'h44);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 64'h48}) begin
            n_mis++; $display("FAIL b2b_entry1: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b0, 64'h48}); end
        look(64'h48);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 64'h600}) begin
            n_mis++; $display("FAIL b2b_entry2: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b1, 1'b1, 64'h600}); end
        n_cmp++; if ({stat_branches_o, stat_mispred_o} !== {32'd18, 32'd10}) begin
            n_mis++; $display("FAIL b2b_stats: got %h want %h", {stat_branches_o, stat_mispred_o}, {32'd18, 32'd10}); end
    endtask

    task automatic test_wrap();
        look(64'hFFFF_FFFF_FFFF_FFFC);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 64'h0}) begin
            n_mis++; $display("FAIL wrap_lookup: got %h want 0", {pred_hit_o, pred_taken_o, pred_next_pc_o}); end
        upd(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 1, 64'h1234); tick(); idle();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b1, 64'h0}) begin
            n_mis++; $display("FAIL wrap_redirect: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b1, 64'h0}); end
    endtask

    task automatic test_reset_mid();
        upd(64'h40, 0, 64'h0, 1, 64'h300); tick();
        n_cmp++; if ({mispredict_o, redirect_pc_o} !== {1'b1, 64'h44}) begin
            n_mis++; $display("FAIL pre_reset_pulse: got %h want %h", {mispredict_o, redirect_pc_o}, {1'b1, 64'h44}); end
        reset = 1'b1;
        upd(64'h80, 1, 64'h700, 0, 64'h0); tick();
        reset = 1'b0; idle();
        n_cmp++; if ({mispredict_o, redirect_pc_o, stat_branches_o, stat_mispred_o} !== 129'h0) begin
            n_mis++; $display("FAIL reset_mid_outputs: got %h want 0", {mispredict_o, redirect_pc_o, stat_branches_o, stat_mispred_o}); end
        look(64'h80);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 64'h84}) begin
            n_mis++; $display("FAIL reset_cycle_update: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b0, 1'b0, 64'h84}); end
        look(64'h48);
        n_cmp++; if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 64'h4C}) begin
            n_mis++; $display("FAIL reset_clears_valid: got %h want %h", {pred_hit_o, pred_taken_o, pred_next_pc_o}, {1'b0, 1'b0, 64'h4C}); end
        tick();
        n_cmp++; if ({mispredict_o, stat_branches_o} !== 33'h0) begin
            n_mis++; $display("FAIL post_reset_quiet: got %h want 0", {mispredict_o, stat_branches_o}); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_correct_pred();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
